alu_op_decoder: RTL and testbench

ALU_OP_DECODER -- requirements
Module: alu_op_decoder

---
 rtl/alu_pkg.sv | 60 ++++++
 rtl/alu_op_encode.sv | 54 +++++
 rtl/alu_op_decoder.sv | 93 +++++++++
 tb/tb_alu_op_decoder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ALU op decoder shared types: op codes, opcodes,
// decoded bundle and buffer state.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       use_imm;
      logic [3:0] imm;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       illegal;
   } dec_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } buf_st_t;

   function automatic logic [3:0] alu_code(
      input logic       alt,
      input logic [2:0] f3
   );
      logic [3:0] code;
      code = ALU_ADD;
      unique case ({alt, f3})
         4'b0000: code = ALU_ADD;
         4'b1000: code = ALU_SUB;
         4'b0001: code = ALU_SLL;
         4'b0101: code = ALU_SRL;
         4'b1101: code = ALU_SRA;
         4'b0010: code = ALU_SLT;
         4'b0011: code = ALU_SLTU;
         4'b0100: code = ALU_XOR;
         4'b0110: code = ALU_OR;
         4'b0111: code = ALU_AND;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/alu_op_encode.sv
// Combinational RV32I OP / OP-IMM decode of one
// instruction word into an ALU bundle.
module alu_op_encode
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   output dec_t        bundle
);

   logic [6:0] opc;
   logic [6:0] f7;
   logic [2:0] f3;
   logic       is_op;
   logic       is_opi;
   logic       op_ok;
   logic       opi_ok;
   logic       is_sh5;

   assign opc    = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];
   assign is_op  = (opc == OP);
   assign is_opi = (opc == OP_IMM);
   assign is_sh5 = (f3 == 3'b101);

   // funct7 alt form only selects SUB/SRA
   assign op_ok = (f7 == F7_BASE) ||
                  ((f7 == F7_ALT) && ((f3 == 3'b000) || is_sh5));

   assign opi_ok = (f3 == 3'b001) ? (f7 == F7_BASE) :
                   is_sh5 ? ((f7 == F7_BASE) || (f7 == F7_ALT)) :
                   1'b1;

   always_comb begin
      bundle     = '0;
      bundle.rd  = instr[11:7];
      bundle.rs1 = instr[19:15];
      bundle.rs2 = instr[24:20];
      bundle.imm = instr[23:20];
      unique case (1'b1)
         (is_op && op_ok): begin
            bundle.alu_op = alu_code(f7[5], f3);
         end
         (is_opi && opi_ok): begin
            bundle.alu_op  = alu_code(f7[5] & is_sh5, f3);
            bundle.use_imm = 1'b1;
         end
         default: begin
            bundle.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_op_decoder.sv
// ALU op decoder with a two-entry output buffer
// and a saturating illegal-instruction counter.
module alu_op_decoder
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  alu_op,
   output logic        use_imm,
   output logic [3:0]  imm,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic        illegal,
   output logic [7:0]  illegal_cnt
);

   dec_t    dec;
   dec_t    head;
   dec_t    tail;
   buf_st_t state;
   logic    acc;
   logic    con;

   alu_op_encode u_enc (
      .instr  (instr),
      .bundle (dec)
   );

   assign acc = in_valid & in_ready;
   assign con = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= EMPTY;
         head        <= '0;
         tail        <= '0;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         illegal_cnt <= '0;
      end else begin
         if (acc && dec.illegal && (illegal_cnt != 8'hFF))
            illegal_cnt <= illegal_cnt + 8'd1;
         unique case (state)
            EMPTY: begin
               if (acc) begin
                  head      <= dec;
                  state     <= ONE;
                  out_valid <= 1'b1;
               end
            end
            ONE: begin
               if (acc && !con) begin
                  tail     <= dec;
                  state    <= TWO;
                  in_ready <= 1'b0;
               end else if (!acc && con) begin
                  state     <= EMPTY;
                  out_valid <= 1'b0;
               end else if (acc && con) begin
                  head <= dec;
               end
            end
            TWO: begin
               if (con) begin
                  head     <= tail;
                  state    <= ONE;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state     <= EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign alu_op  = head.alu_op;
   assign use_imm = head.use_imm;
   assign imm     = head.imm;
   assign rd      = head.rd;
   assign rs1     = head.rs1;
   assign rs2     = head.rs2;
   assign illegal = head.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Scoreboard bench for alu_op_decoder: decode table,
// backpressure, counter saturation and reset flush.
module tb_alu_op_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instr = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  alu_op;
   logic        use_imm;
   logic [3:0]  imm;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        illegal;
   logic [7:0]  illegal_cnt;

   int checks = 0;
   int failures = 0;

   logic [24:0] sb[$];

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_SUB  = 32'h402081B3;
   localparam logic [31:0] I_SLTU = 32'h0020B1B3;
   localparam logic [31:0] I_ILL  = 32'h00000073;

   always #5 clk = ~clk;

   alu_op_decoder dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instr       (instr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .alu_op      (alu_op),
      .use_imm     (use_imm),
      .imm         (imm),
      .rd          (rd),
      .rs1         (rs1),
      .rs2         (rs2),
      .illegal     (illegal),
      .illegal_cnt (illegal_cnt)
   );

   function automatic logic [24:0] mk(
      input logic [3:0] a, input logic u, input logic [3:0] im,
      input logic [4:0] d, input logic [4:0] s1,
      input logic [4:0] s2, input logic il
   );
      return {a, u, im, d, s1, s2, il};
   endfunction

   function automatic logic [24:0] obs();
      return {alu_op, use_imm, imm, rd, rs1, rs2, illegal};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      instr = I_ILL;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_hs out_valid=%b in_ready=%b want 0/1",
                  out_valid, in_ready);
      end
      checks++;
      if (illegal_cnt !== 8'd0 || obs() !== 25'd0) begin
         failures++;
         $display("FAIL reset_regs cnt=%0d bundle=%h want 0/0",
                  illegal_cnt, obs());
      end
      sb.delete();
   endtask

   task automatic test_decode();
      logic [31:0] din [11];
      logic [24:0] dex [11];
      logic [24:0] e;
      int idx;
      int cyc;
      din[0]  = I_ADD;        dex[0]  = mk(4'h0, 0, 4'h2, 3, 1, 2, 0);
      din[1]  = I_SUB;        dex[1]  = mk(4'h8, 0, 4'h2, 3, 1, 2, 0);
      din[2]  = 32'hFFF00093; dex[2]  = mk(4'h0, 1, 4'hF, 1, 0, 31, 0);
      din[3]  = 32'h40235293; dex[3]  = mk(4'hD, 1, 4'h2, 5, 6, 2, 0);
      din[4]  = I_ILL;        dex[4]  = mk(4'h0, 0, 4'h0, 0, 0, 0, 1);
      din[5]  = 32'h4020C1B3; dex[5]  = mk(4'h0, 0, 4'h2, 3, 1, 2, 1);
      din[6]  = 32'h02009093; dex[6]  = mk(4'h0, 0, 4'h0, 1, 1, 0, 1);
      din[7]  = 32'h4000C093; dex[7]  = mk(4'h4, 1, 4'h0, 1, 1, 0, 0);
      din[8]  = 32'h4020D1B3; dex[8]  = mk(4'hD, 0, 4'h2, 3, 1, 2, 0);
      din[9]  = 32'h0020F1B3; dex[9]  = mk(4'h7, 0, 4'h2, 3, 1, 2, 0);
      din[10] = I_SLTU;       dex[10] = mk(4'h3, 0, 4'h2, 3, 1, 2, 0);
      idx = 0;
      cyc = 0;
      out_ready = 1'b1;
      while ((idx < 11 || sb.size() != 0) && cyc < 100) begin
         if (cyc == 1) begin
            checks++;
            if (out_valid !== 1'b1) begin
               failures++;
               $display("FAIL latency out_valid=%b want 1", out_valid);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL decode_extra got=%h want none", obs());
            end else begin
               e = sb.pop_front();
               if (obs() !== e) begin
                  failures++;
                  $display("FAIL decode got=%h want=%h", obs(), e);
               end
            end
         end
         in_valid = (idx < 11);
         instr = (idx < 11) ? din[idx] : 32'h0;
         if (in_valid && in_ready) begin
            sb.push_back(dex[idx]);
            idx++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (cyc >= 100) begin
         failures++;
         $display("FAIL decode_timeout left=%0d want 0", sb.size());
      end
      checks++;
      if (illegal_cnt !== 8'd3) begin
         failures++;
         $display("FAIL decode_cnt got=%0d want 3", illegal_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] din [3];
      logic [24:0] e;
      int idx;
      int cyc;
      din[0] = I_ADD;
      din[1] = I_SUB;
      din[2] = I_SLTU;
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         instr = din[i];
         checks++;
         if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready%0d got=%b want 1", i, in_ready);
         end
         tick();
      end
      sb.push_back(mk(4'h0, 0, 4'h2, 3, 1, 2, 0));
      sb.push_back(mk(4'h8, 0, 4'h2, 3, 1, 2, 0));
      instr = din[2];
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_full in_ready=%b out_valid=%b want 0/1",
                     in_ready, out_valid);
         end
         checks++;
         if (obs() !== sb[0]) begin
            failures++;
            $display("FAIL b2b_hold got=%h want=%h", obs(), sb[0]);
         end
         tick();
      end
      idx = 2;
      cyc = 0;
      out_ready = 1'b1;
      while ((idx < 3 || sb.size() != 0) && cyc < 50) begin
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL b2b_extra got=%h want none", obs());
            end else begin
               e = sb.pop_front();
               if (obs() !== e) begin
                  failures++;
                  $display("FAIL b2b_order got=%h want=%h", obs(), e);
               end
            end
         end
         in_valid = (idx < 3);
         instr = (idx < 3) ? din[idx] : 32'h0;
         if (in_valid && in_ready) begin
            sb.push_back(mk(4'h3, 0, 4'h2, 3, 1, 2, 0));
            idx++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (cyc >= 50 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drain cyc=%0d out_valid=%b want <50/0",
                  cyc, out_valid);
      end
   endtask

   task automatic test_saturate();
      int n;
      int cyc;
      test_reset();
      n = 0;
      cyc = 0;
      out_ready = 1'b1;
      while (n < 256 && cyc < 600) begin
         in_valid = 1'b1;
         instr = I_ILL;
         if (in_ready) n++;
         tick();
         cyc++;
         if (n == 254 || n == 255) begin
            checks++;
            if (illegal_cnt !== n[7:0]) begin
               failures++;
               $display("FAIL sat_count got=%0d want=%0d", illegal_cnt, n);
            end
         end
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (n != 256 || illegal_cnt !== 8'd255) begin
         failures++;
         $display("FAIL sat_final n=%0d cnt=%0d want 256/255",
                  n, illegal_cnt);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1;
      instr = I_ADD;
      tick();
      instr = I_SUB;
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL mid_full in_ready=%b out_valid=%b want 0/1",
                  in_ready, out_valid);
      end
      rst = 1'b1;
      out_ready = 1'b1;
      instr = I_ILL;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_hs out_valid=%b in_ready=%b want 0/1",
                  out_valid, in_ready);
      end
      checks++;
      if (illegal_cnt !== 8'd0 || obs() !== 25'd0) begin
         failures++;
         $display("FAIL mid_regs cnt=%0d bundle=%h want 0/0",
                  illegal_cnt, obs());
      end
      sb.delete();
      in_valid = 1'b1;
      instr = I_SUB;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 ||
          obs() !== mk(4'h8, 0, 4'h2, 3, 1, 2, 0)) begin
         failures++;
         $display("FAIL mid_after out_valid=%b got=%h want 1/%h",
                  out_valid, obs(), mk(4'h8, 0, 4'h2, 3, 1, 2, 0));
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_decode();
      test_back_to_back();
      test_saturate();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
